// File: rtl/rally_scorer.sv
// Rally scoring controller: serves, awards points on ball exit, tracks scores and declares a winner.
// Optional macro DEUCE_EN selects win-by-two scoring.
module rally_scorer #(
    parameter int unsigned WIN_SCORE  = 7,
    parameter logic [25:0] POINT_HOLD = 26'd50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] light,
    input  logic [1:0]  direction,
    output logic [1:0]  serve,
    output logic [3:0]  score_left,
    output logic [3:0]  score_right,
    output logic        point,
    output logic [1:0]  winner
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SERVE,
        S_RALLY,
        S_POINT,
        S_OVER
    } state_t;

    localparam logic [1:0] NONE  = 2'b00;
    localparam logic [1:0] LEFT  = 2'b01;
    localparam logic [1:0] RIGHT = 2'b10;
    localparam logic [3:0] WIN   = 4'(WIN_SCORE);
`ifdef DEUCE_EN
    localparam logic [3:0] WIN_CAP = 4'(WIN_SCORE + 1);
    localparam logic [3:0] WIN_M1  = 4'(WIN_SCORE - 1);
`endif

    // Post-increment score pair {gainer, other} for one awarded point.
    function automatic logic [7:0] add_point(input logic [3:0] gain, input logic [3:0] other);
        logic [3:0] g;
        logic [3:0] o;
        g = gain;
        o = other;
`ifdef DEUCE_EN
        if (g < WIN_CAP) g = g + 4'd1;
        if (g == o && g >= WIN_M1) begin
            g = g - 4'd1;
            o = o - 4'd1;
        end
`else
        if (g < WIN) g = g + 4'd1;
`endif
        return {g, o};
    endfunction

    function automatic logic [1:0] win_code(input logic [3:0] l, input logic [3:0] r);
        logic [1:0] code;
        code = NONE;
`ifdef DEUCE_EN
        if (l >= WIN && {1'b0, l} >= {1'b0, r} + 5'd2) code = LEFT;
        else if (r >= WIN && {1'b0, r} >= {1'b0, l} + 5'd2) code = RIGHT;
`else
        if (l == WIN) code = LEFT;
        else if (r == WIN) code = RIGHT;
`endif
        return code;
    endfunction

    logic [15:0] light_q;
    logic [1:0]  dir_q;
    logic        start_q;
    logic        start_prev;
    logic        sampled;
    logic        armed;
    logic        start_evt_c;

    // Input capture; armed only after a genuine low start sample so a held button cannot fire.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            light_q    <= '0;
            dir_q      <= '0;
            start_q    <= 1'b0;
            start_prev <= 1'b0;
            sampled    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            light_q    <= light;
            dir_q      <= direction;
            start_q    <= start;
            start_prev <= start_q;
            sampled    <= 1'b1;
            armed      <= armed | (sampled & ~start_q);
        end
    end

    assign start_evt_c = armed & start_q & ~start_prev;

    state_t      state, state_next;
    logic [1:0]  server, server_next;
    logic [1:0]  last_dir, last_dir_next;
    logic [25:0] hold_cnt, hold_next;
    logic [1:0]  serve_next;
    logic [3:0]  left_next, right_next;
    logic        point_next;
    logic [1:0]  winner_next;
    logic [7:0]  left_gain_c;
    logic [7:0]  right_gain_c;
    logic [1:0]  result_c;

    assign left_gain_c  = add_point(score_left, score_right);
    assign right_gain_c = add_point(score_right, score_left);
    assign result_c     = win_code(score_left, score_right);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            server      <= LEFT;
            last_dir    <= NONE;
            hold_cnt    <= '0;
            serve       <= NONE;
            score_left  <= '0;
            score_right <= '0;
            point       <= 1'b0;
            winner      <= NONE;
        end else begin
            state       <= state_next;
            server      <= server_next;
            last_dir    <= last_dir_next;
            hold_cnt    <= hold_next;
            serve       <= serve_next;
            score_left  <= left_next;
            score_right <= right_next;
            point       <= point_next;
            winner      <= winner_next;
        end
    end

    always_comb begin
        state_next    = state;
        server_next   = server;
        last_dir_next = last_dir;
        hold_next     = hold_cnt;
        serve_next    = NONE;
        left_next     = score_left;
        right_next    = score_right;
        point_next    = 1'b0;
        winner_next   = winner;
        case (state)
            S_IDLE, S_OVER: begin
                if (start_evt_c) begin
                    state_next  = S_SERVE;
                    left_next   = '0;
                    right_next  = '0;
                    winner_next = NONE;
                    server_next = LEFT;
                    serve_next  = LEFT;
                end
            end
            S_SERVE: begin
                if (light_q != '0) begin
                    state_next    = S_RALLY;
                    last_dir_next = NONE;
                end else begin
                    serve_next = server;
                end
            end
            S_RALLY: begin
                if (dir_q != NONE) last_dir_next = dir_q;
                // Ball left the court: the player it was heading toward missed.
                if (light_q == '0) begin
                    if (last_dir == LEFT) begin
                        {right_next, left_next} = right_gain_c;
                        server_next = RIGHT;
                        point_next  = 1'b1;
                        hold_next   = '0;
                        state_next  = S_POINT;
                    end else if (last_dir == RIGHT) begin
                        {left_next, right_next} = left_gain_c;
                        server_next = LEFT;
                        point_next  = 1'b1;
                        hold_next   = '0;
                        state_next  = S_POINT;
                    end else begin
                        state_next = S_SERVE;
                        serve_next = server;
                    end
                end
            end
            S_POINT: begin
                if (hold_cnt + 26'd1 >= POINT_HOLD) begin
                    hold_next = '0;
                    if (result_c != NONE) begin
                        state_next  = S_OVER;
                        winner_next = result_c;
                    end else begin
                        state_next = S_SERVE;
                        serve_next = server;
                    end
                end else begin
                    hold_next = hold_cnt + 26'd1;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

endmodule

// File: doc/rally_scorer.md
RALLY_SCORER -- requirements
Module: rally_scorer

Interface
REQ-001 Parameter WIN_SCORE, default 7, points needed to win a game; legal range 2..15.
REQ-002 Parameter POINT_HOLD, default 26'd50_000_000, number of clock cycles the POINT state is held before the next serve.
REQ-003 clock  input  1  single system clock; all logic is on its rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  player start button, level input, synchronous to clock.
REQ-006 light  input  16  ball position from the ball stage; one-hot while the ball is in play, 16'h0000 when the ball has left the court.
REQ-007 direction  input  2  ball direction: 2'b01 = travelling toward light[15] (left player), 2'b10 = toward light[0] (right player), 2'b00 = idle.
REQ-008 serve  output  2  serve request to the ball stage: 2'b01 = left player serves, 2'b10 = right player serves, 2'b00 = none.
REQ-009 score_left, score_right  output  4 each  current game scores.
REQ-010 point  output  1  one-cycle pulse on every awarded point.
REQ-011 winner  output  2  2'b01 = left won, 2'b10 = right won, 2'b00 = game in progress.

Function
REQ-012 light, direction and start SHALL be registered once before use; all event detection uses the registered copies.
REQ-013 start SHALL be edge-detected; only a 0->1 transition of the registered start counts as a start event.
REQ-014 FSM states: IDLE, SERVE, RALLY, POINT, OVER.
REQ-015 IDLE: serve=00; a start event -> SERVE, scores cleared, left player is the server.
REQ-016 SERVE: serve holds the current server code until the registered light is nonzero, then serve=00 and the FSM goes to RALLY on the same edge.
REQ-017 RALLY: last_dir SHALL capture every nonzero registered direction.
REQ-018 RALLY: when the registered light becomes 16'h0000, the point SHALL be awarded against last_dir. last_dir=01 means the left player missed, so right scores. last_dir=10 means the right player missed, so left scores. The FSM goes to POINT and point pulses for one cycle.
REQ-019 If last_dir is 00 when the ball exits, no point SHALL be awarded and the FSM SHALL return to SERVE with the server unchanged.
REQ-020 The scoring player SHALL be the next server.
REQ-021 POINT: a 26-bit counter SHALL count POINT_HOLD cycles. Afterwards the FSM goes to OVER if a win condition holds, else to SERVE.
REQ-022 Win condition (default build): a score equals WIN_SCORE. Score increments SHALL never exceed WIN_SCORE.
REQ-023 OVER: winner holds the winner code and serve=00. A start event clears scores and winner, sets the left player as server, and goes to SERVE.
REQ-024 Start events in SERVE, RALLY and POINT SHALL be ignored.
REQ-025 The score update and the winner evaluation SHALL use the post-increment score value.

Reset
REQ-026 Reset asserted (reset=0) at any time, including mid-rally or mid-POINT, SHALL immediately force these values: state=IDLE, serve=00, both scores=0, point=0, winner=00, last_dir=00, hold counter=0, all input registers=0.
REQ-027 After reset deasserts, no start event SHALL be detected while start is already high; a fresh 0->1 transition is required.

Configuration
REQ-028 Macro DEUCE_EN enables win-by-two scoring; without it, scoring follows REQ-022.
REQ-029 With DEUCE_EN defined, after an increment that leaves the scores tied at or above WIN_SCORE-1, both scores SHALL be decremented by 1.
REQ-030 With DEUCE_EN defined, the win condition is: a score is at least WIN_SCORE and exceeds the other score by at least 2. Scores SHALL never exceed WIN_SCORE+1.

Verification
REQ-031 Reset, then a start pulse -> serve=01 from the cycle after the start edge is registered; light=16'h0001 -> serve=00 and RALLY entered.
REQ-032 RALLY with direction=01, then light=0 -> score_right=1, point pulses for exactly 1 cycle, and after POINT_HOLD (8 in bench) cycles serve=10.
REQ-033 Default build, WIN_SCORE=3, right wins 3 points -> winner=10 and state OVER; a start pulse -> scores 0/0, winner=00, serve=01.
REQ-034 DEUCE_EN build, WIN_SCORE=3, scores reach 2/2 -> scores become 1/1; from there, left scores twice -> scores 3/1 and winner=01.
REQ-035 reset pulled low mid-POINT with the counter at 4 -> all outputs are 0 immediately; a start held high through reset release -> no serve.
REQ-036 A start pulse during RALLY -> state, scores and serve unchanged; light exiting with last_dir=00 -> no point, serve re-asserted with the same server.
